// File: rtl/regfile_dbg_pkg.sv
// Shared types and defaults for the register-file dump engine.
package regfile_dbg_pkg;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_DATA_W   = 32;
  localparam logic [31:0] SP_RESET_VAL = 32'h0000_2ffc;

  typedef enum logic [2:0] {IDLE, READ, SEND0, SEND1, DONE} state_e;
endpackage

// File: rtl/regfile_dump_engine.sv
// Debug reader: borrows the register file's two async read ports while the core
// is stalled and streams every register out as (index, data) words.
module regfile_dump_engine
  import regfile_dbg_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rf_grant,
  output logic [IDX_W-1:0]  rf_rs1,
  output logic [IDX_W-1:0]  rf_rs2,
  input  logic [DATA_W-1:0] rf_rs1_dout,
  input  logic [DATA_W-1:0] rf_rs2_dout,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data
);
  localparam int PAIR_W = IDX_W - 1;
  localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NUM_REGS/2 - 1);

  state_e            r_state;
  logic [PAIR_W-1:0] r_pair;
  logic [DATA_W-1:0] r_buf1;
  logic [PAIR_W-1:0] w_next_pair;

  assign w_next_pair = r_pair + PAIR_W'(1);

  // out_data doubles as the even-word buffer; r_buf1 parks the odd word
  // until the even one is accepted. Read addresses are only ever updated on
  // the transition into READ, so they are stable for the whole READ cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pair    <= '0;
      r_buf1    <= '0;
      rf_rs1    <= '0;
      rf_rs2    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state <= READ;
            r_pair  <= '0;
            rf_rs1  <= '0;
            rf_rs2  <= IDX_W'(1);
            busy    <= 1'b1;
          end
        end
        READ: begin
          if (rf_grant) begin
            out_data  <= rf_rs1_dout;
            r_buf1    <= rf_rs2_dout;
            out_idx   <= rf_rs1;
            out_valid <= 1'b1;
            r_state   <= SEND0;
          end
        end
        SEND0: begin
          if (out_ready) begin
            out_idx  <= rf_rs2;
            out_data <= r_buf1;
            r_state  <= SEND1;
          end
        end
        SEND1: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (r_pair == LAST_PAIR) begin
              r_state <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_pair  <= w_next_pair;
              rf_rs1  <= {w_next_pair, 1'b0};
              rf_rs2  <= {w_next_pair, 1'b1};
              r_state <= READ;
            end
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_dump_engine.sv
// Randomized bench: register-file model, expected stream built from a snapshot.
module tb_regfile_dump_engine;
  import regfile_dbg_pkg::*;
  localparam int NR = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset, start, rf_grant, out_ready;
  logic [4:0]    rf_rs1, rf_rs2, out_idx;
  logic [DW-1:0] rf_rs1_dout, rf_rs2_dout, out_data;
  logic          busy, done, out_valid;
  logic [DW-1:0] regs [NR];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Without the grant the ports belong to the core: present junk.
  assign rf_rs1_dout = rf_grant ? regs[rf_rs1] : ~regs[rf_rs1];
  assign rf_rs2_dout = rf_grant ? regs[rf_rs2] : ~regs[rf_rs2];

  regfile_dump_engine #(.NUM_REGS(NR), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .rf_grant(rf_grant),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .rf_rs1_dout(rf_rs1_dout), .rf_rs2_dout(rf_rs2_dout),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // rmode: 0 ready=1, 1 toggle, 2 random. gmode: 0 grant=1, 1 withheld 5
  // cycles then dropped during sends, 2 random. restart_word: pulse start
  // when that word is offered. rst_idx: assert reset while that idx is valid.
  task automatic do_dump(input int rmode, input int gmode, input int restart_word, input int rst_idx);
    logic [DW-1:0] snap [NR];
    int got, hs_last, cyc;
    bit pstall, fin;
    logic [4:0] pidx;
    logic [DW-1:0] pdata;
    got = 0; hs_last = -1; cyc = 0; pstall = 0; fin = 0; pidx = '0; pdata = '0;
    for (int i = 0; i < NR; i++) snap[i] = regs[i];
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!fin && cyc < 600) begin
      if (pstall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_idx", out_idx, pidx);
        chk("hold_data", out_data, pdata);
      end
      if (done) begin
        chk("done_lat", cyc, hs_last + 1);
        chk("done_words", got, NR);
        chk("done_busy", busy, 0);
        if (rmode == 0 && gmode == 0) chk("dump_cycles", hs_last + 1, 48);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("idle_busy", busy, 0);
        fin = 1;
      end else begin
        chk("busy", busy, 1);
        if (!out_valid) begin
          chk("rs1", rf_rs1, got);
          chk("rs2", rf_rs2, got + 1);
        end
        if (gmode == 1 && cyc <= 5) chk("grant_wait", out_valid, 0);
        if (gmode == 1 && cyc == 6) chk("grant_lat", out_valid, 1);
        if (rst_idx >= 0 && out_valid && out_idx == rst_idx[4:0]) begin
          reset = 1'b1;
          @(negedge clk); reset = 1'b0;
          chk("rst_valid", out_valid, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          @(negedge clk);
          chk("rst_nodone", done, 0);
          return;
        end
        out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
        rf_grant  = (gmode == 0) ? 1'b1 : (gmode == 1) ? (cyc >= 5 && !out_valid)
                                                       : 1'($urandom_range(0, 1));
        start = (restart_word >= 0 && got == restart_word);
        if (out_valid && out_ready) begin
          if (got < NR) begin
            chk("idx", out_idx, got);
            chk("data", out_data, snap[got]);
          end else chk("extra_word", got, NR - 1);
          got++;
          hs_last = cyc;
        end
        pstall = out_valid && !out_ready;
        pidx   = out_idx;
        pdata  = out_data;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (!fin) chk("timeout", 0, 1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rf_grant = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < NR; i++) regs[i] = '0;
    regs[2] = SP_RESET_VAL;
    repeat (3) @(negedge clk);
    chk("rst_busy0", busy, 0);
    chk("rst_done0", done, 0);
    chk("rst_valid0", out_valid, 0);
    chk("rst_idx0", out_idx, 0);
    chk("rst_data0", out_data, 0);
    chk("rst_rs1_0", rf_rs1, 0);
    chk("rst_rs2_0", rf_rs2, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy0", busy, 0);

    do_dump(0, 0, -1, -1);
    regs[5] = 32'hDEAD_BEEF;
    regs[31] = 32'h1;
    do_dump(0, 0, -1, -1);
    do_dump(1, 0, -1, -1);
    do_dump(0, 1, -1, -1);
    do_dump(0, 0, 10, -1);
    do_dump(0, 0, -1, 7);
    do_dump(0, 0, -1, -1);
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NR; i++) regs[i] = $urandom;
      do_dump(2, 2, (t == 3) ? int'($urandom_range(1, 30)) : -1, -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
